hsv_threshold_sequencer: RTL and testbench
==========================================

# hsv_threshold_sequencer

Frame-synchronous configuration controller for the HSV colour-reduction datapath. It takes user threshold edits (select strobe, channel selector, 3-bit value) and turns each into an 8-bit MSB mask. Edits are held in shadow registers and committed to the live H/S/V threshold outputs only at a frame-start boundary, so a frame is never reduced with mixed thresholds. After each commit it asserts a busy window that covers the downstream rgb→hsv→reduce→rgb→contrast pipeline latency, so consumers can discard pixels that are still in flight under the old thresholds.

## Interface

Parameters:
- PIPE_LAT, 8: cycles of downstream pipeline latency to cover after a commit; legal range 1..255.
- H_DEFAULT, 8'hF0: reset value of the active and shadow H mask.
- S_DEFAULT, 8'hE0: reset value of the active and shadow S mask.
- V_DEFAULT, 8'hE0: reset value of the active and shadow V mask.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- select  in  1  user commit strobe, level input (already debounced); its rising edge is the event.
- selector  in  2  target channel: 00=H, 01=S, 10=V, 11=all three.
- inputVal  in  3  mask code n; the mask keeps n+1 MSBs.
- vsync  in  1  active-high frame sync; its rising edge marks frame start.
- hThreshold  out  8  live H mask.
- sThreshold  out  8  live S mask.
- vThreshold  out  8  live V mask.
- pending  out  1  shadow holds at least one uncommitted edit.
- upd_pulse  out  1  one-cycle pulse, high in the cycle after a commit.
- cfg_busy  out  1  high for PIPE_LAT cycles after a commit.

## Operation

- Edge detection uses registers sel_q and vs_q. A rising edge is detected when the input is 1 and its register is 0.
  - Both registers reset to 1, so a level held high through reset release is not an edge.
- Mask encoding: mask = ~(8'hFF >> (inputVal+1)), all in 8-bit arithmetic.
  - inputVal=0 → 8'h80; inputVal=3 → 8'hF0; inputVal=7 → 8'hFF.
- A select edge writes the mask into the shadow register(s) named by selector and sets the pend flag.
  - With selector 11, all three shadows are written.
  - A later edit to the same channel overwrites the earlier one.
- FSM states and transitions:
  - IDLE: a select edge writes the shadow → PENDING. A vsync edge is ignored.
  - PENDING: a select edge updates the shadow and stays in PENDING. A vsync edge commits: active ← shadow, pend ← 0, counter ← PIPE_LAT−1, → SETTLE.
  - SETTLE: the counter decrements each cycle. A select edge updates the shadow and sets pend. A vsync edge is ignored, so no commit happens during SETTLE. When the counter reaches 0 and pend=0 → IDLE; when the counter reaches 0 and pend=1 → PENDING.
- Simultaneous select edge and vsync edge in PENDING: the concurrent edit is merged into the committed value (the shadow write bypasses into active). pend ends at 0.
- Active registers change only on a commit. Shadow registers change only on a select edge or reset.
- Reset (asynchronous, including mid-SETTLE):
  - state=IDLE, counter=0, pend=0.
  - active and shadow masks = the defaults.
  - hThreshold/sThreshold/vThreshold = H_DEFAULT/S_DEFAULT/V_DEFAULT.
  - pending=0, upd_pulse=0, cfg_busy=0.

## Timing

- All outputs are registered; none has a combinational input-to-output path.
- pending = pend register. It rises in the cycle after the first select edge and falls in the cycle after a commit.
- Commit latency: a vsync edge detected in cycle k gives:
  - new thresholds visible from cycle k+1;
  - upd_pulse=1 in cycle k+1 only;
  - cfg_busy=1 in cycles k+1 .. k+PIPE_LAT, and 0 in cycle k+PIPE_LAT+1.
- A commit cannot recur sooner than PIPE_LAT+1 cycles after the previous one.
- A select edge that is held high for several cycles counts as exactly one edit.

## Test plan

- Reset check: drive reset=0 mid-run, then release → outputs are F0/E0/E0, pending=0, cfg_busy=0. With select high through the release, no edit registers.
- Basic commit: selector=00, inputVal=1, select pulse, then a vsync edge 100 cycles later. hThreshold stays F0 until the cycle after vsync, then becomes C0. upd_pulse lasts 1 cycle. cfg_busy is high for exactly 8 cycles.
- All-channel edit: selector=11, inputVal=7, then vsync. All three thresholds become FF. A vsync with no edit pending leaves the thresholds unchanged and upd_pulse=0.
- Edit during SETTLE: commit V=80 (inputVal=0). At settle cycle 3, edit S with inputVal=2. A vsync at settle cycle 5 is ignored: sThreshold stays E0 and pending=1. The next vsync after settle commits S=E0 (code 2 → E0); then repeat the test with inputVal=4 → F8.
- Simultaneous events: in PENDING (H edit, code 3), a select edge for V with code 5 lands in the same cycle as the vsync edge. The next cycle shows hThreshold=F0 and vThreshold=FC, with pending=0.
- Reset mid-SETTLE: assert reset at settle cycle 4 → cfg_busy drops to 0 asynchronously and the thresholds return to the defaults. After release, the FSM is IDLE.

Source files
------------

// File: rtl/hsv_threshold_sequencer.sv
// Frame-synchronous threshold controller: user edits land in shadow masks and
// are committed to the live H/S/V masks on a frame start, followed by a busy window.
module hsv_threshold_sequencer #(
  parameter int unsigned PIPE_LAT  = 8,
  parameter logic [7:0]  H_DEFAULT = 8'hF0,
  parameter logic [7:0]  S_DEFAULT = 8'hE0,
  parameter logic [7:0]  V_DEFAULT = 8'hE0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       select,
  input  logic [1:0] selector,
  input  logic [2:0] inputVal,
  input  logic       vsync,
  output logic [7:0] hThreshold,
  output logic [7:0] sThreshold,
  output logic [7:0] vThreshold,
  output logic       pending,
  output logic       upd_pulse,
  output logic       cfg_busy
);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_SETTLE} state_e;

  localparam logic [7:0] CNT_INIT = 8'(PIPE_LAT - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       sel_q, vs_q, pend_q, upd_q, busy_q;
  logic [7:0] h_sh_q, s_sh_q, v_sh_q;
  logic [7:0] h_sh_d, s_sh_d, v_sh_d;
  logic [7:0] h_act_q, s_act_q, v_act_q;
  logic [3:0] keep;
  logic [7:0] mask;
  logic       sel_edge, vs_edge, commit;

  // NOTE: every signal gets a default before any branch so always_comb never infers a latch.
  always_comb begin
    keep     = {1'b0, inputVal} + 4'd1;
    mask     = ~(8'hFF >> keep);
    sel_edge = select & ~sel_q;
    vs_edge  = vsync & ~vs_q;
    commit   = vs_edge && (state_q == S_PENDING);
    h_sh_d   = h_sh_q;
    s_sh_d   = s_sh_q;
    v_sh_d   = v_sh_q;
    if (sel_edge) begin
      case (selector)
        2'b00:   h_sh_d = mask;
        2'b01:   s_sh_d = mask;
        2'b10:   v_sh_d = mask;
        default: begin
          h_sh_d = mask;
          s_sh_d = mask;
          v_sh_d = mask;
        end
      endcase
    end
  end

  // Committing the _d shadows lets an edit in the commit cycle bypass into the live masks.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b1;
      vs_q    <= 1'b1;
      pend_q  <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      h_sh_q  <= H_DEFAULT;
      s_sh_q  <= S_DEFAULT;
      v_sh_q  <= V_DEFAULT;
      h_act_q <= H_DEFAULT;
      s_act_q <= S_DEFAULT;
      v_act_q <= V_DEFAULT;
    end else begin
      sel_q  <= select;
      vs_q   <= vsync;
      h_sh_q <= h_sh_d;
      s_sh_q <= s_sh_d;
      v_sh_q <= v_sh_d;
      upd_q  <= commit;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (sel_edge) begin
            pend_q  <= 1'b1;
            state_q <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (commit) begin
            h_act_q <= h_sh_d;
            s_act_q <= s_sh_d;
            v_act_q <= v_sh_d;
            pend_q  <= 1'b0;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            state_q <= S_SETTLE;
          end else if (sel_edge) begin
            pend_q <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (sel_edge) pend_q <= 1'b1;
          if (cnt_q == 8'd0) begin
            busy_q  <= 1'b0;
            state_q <= (pend_q || sel_edge) ? S_PENDING : S_IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign hThreshold = h_act_q;
  assign sThreshold = s_act_q;
  assign vThreshold = v_act_q;
  assign pending    = pend_q;
  assign upd_pulse  = upd_q;
  assign cfg_busy   = busy_q;

endmodule

// File: tb/tb_hsv_threshold_sequencer.sv
// Directed bench for hsv_threshold_sequencer; committed thresholds are checked
// against a scoreboard queue filled when each committing vsync is driven.
module tb_hsv_threshold_sequencer;

  localparam int PIPE_LAT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       select, vsync;
  logic [1:0] selector;
  logic [2:0] inputVal;
  logic [7:0] hThreshold, sThreshold, vThreshold;
  logic       pending, upd_pulse, cfg_busy;

  typedef struct {
    logic [7:0] h;
    logic [7:0] s;
    logic [7:0] v;
  } thr_t;

  thr_t exp_q[$];
  thr_t sh, act;
  int   n_cmp  = 0;
  int   n_fail = 0;

  hsv_threshold_sequencer #(.PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .reset(reset), .select(select), .selector(selector),
    .inputVal(inputVal), .vsync(vsync), .hThreshold(hThreshold),
    .sThreshold(sThreshold), .vThreshold(vThreshold), .pending(pending),
    .upd_pulse(upd_pulse), .cfg_busy(cfg_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mask with n+1 leading ones, built bit by bit.
  function automatic logic [7:0] tb_mask(input int n);
    logic [7:0] m = 8'h00;
    for (int i = 0; i <= n; i++) m[7-i] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sh  = '{8'hF0, 8'hE0, 8'hE0};
    act = sh;
  endtask

  task automatic model_edit(input logic [1:0] sel, input int val);
    logic [7:0] m;
    m = tb_mask(val);
    if (sel == 2'd0 || sel == 2'd3) sh.h = m;
    if (sel == 2'd1 || sel == 2'd3) sh.s = m;
    if (sel == 2'd2 || sel == 2'd3) sh.v = m;
  endtask

  task automatic edit(input logic [1:0] sel, input int val, input int hold);
    selector = sel;
    inputVal = 3'(val);
    select   = 1'b1;
    model_edit(sel, val);
    repeat (hold) tick();
    select = 1'b0;
    tick();
  endtask

  task automatic check_thr(input string tag);
    check({tag, "_h"}, hThreshold, act.h);
    check({tag, "_s"}, sThreshold, act.s);
    check({tag, "_v"}, vThreshold, act.v);
  endtask

  // Drives a committing vsync edge and samples in the first settle cycle.
  task automatic do_commit(input string tag);
    act = sh;
    exp_q.push_back(act);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    @(negedge clk);
    check({tag, "_upd"}, upd_pulse, 1);
    check({tag, "_busy"}, cfg_busy, 1);
    check({tag, "_pend"}, pending, 0);
    check_thr(tag);
  endtask

  task automatic wait_not_busy(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cfg_busy === 1'b0) break;
    end
    check({tag, "_busy_clear"}, cfg_busy, 0);
  endtask

  // Called at the first settle cycle: edit at settle cycle 3, ignored vsync at cycle 5.
  task automatic settle_edit(input string tag, input logic [1:0] sel, input int val);
    tick();
    tick();
    edit(sel, val, 1);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    @(negedge clk);
    check({tag, "_upd_ignored"}, upd_pulse, 0);
    check({tag, "_busy_mid"}, cfg_busy, 1);
    check({tag, "_pend_mid"}, pending, 1);
    check_thr({tag, "_held"});
    wait_not_busy(tag);
    check({tag, "_pend_after"}, pending, 1);
    tick();
  endtask

  // Scoreboard: every upd_pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (upd_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_upd", upd_pulse, 0);
      end else begin
        thr_t e;
        e = exp_q.pop_front();
        check("sb_h", hThreshold, e.h);
        check("sb_s", sThreshold, e.s);
        check("sb_v", vThreshold, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    select   = 1'b1;
    vsync    = 1'b0;
    selector = 2'd0;
    inputVal = 3'd0;
    model_reset();

    // Reset with select held high through release: no edit registers.
    repeat (3) tick();
    check_thr("rst");
    check("rst_pend", pending, 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_upd", upd_pulse, 0);
    reset = 1'b1;
    repeat (3) tick();
    check("rel_sel_high_pend", pending, 0);
    select = 1'b0;
    tick();

    // Basic commit: H code 1 held high three cycles counts as one edit.
    edit(2'd0, 1, 3);
    @(negedge clk);
    check("basic_pend", pending, 1);
    check("basic_h_before", hThreshold, 8'hF0);
    repeat (100) tick();
    check("basic_h_wait", hThreshold, 8'hF0);
    do_commit("basic");
    check("basic_h_c0", hThreshold, 8'hC0);
    for (int i = 2; i <= PIPE_LAT; i++) begin
      @(negedge clk);
      check("basic_busy_hold", cfg_busy, 1);
      check("basic_upd_once", upd_pulse, 0);
    end
    @(negedge clk);
    check("basic_busy_end", cfg_busy, 0);
    tick();

    // Edits during SETTLE: V code 0, then S code 2, then S code 4.
    edit(2'd2, 0, 1);
    do_commit("v80");
    check("v80_v", vThreshold, 8'h80);
    settle_edit("s2", 2'd1, 2);
    do_commit("s2c");
    check("s2_s", sThreshold, 8'hE0);
    settle_edit("s4", 2'd1, 4);
    do_commit("s4c");
    check("s4_s", sThreshold, 8'hF8);
    wait_not_busy("s4c");
    tick();

    // All-channel edit, then a vsync with nothing pending.
    edit(2'd3, 7, 1);
    do_commit("all");
    check("all_h", hThreshold, 8'hFF);
    wait_not_busy("all");
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    @(negedge clk);
    check("idle_vs_upd", upd_pulse, 0);
    check("idle_vs_busy", cfg_busy, 0);
    check_thr("idle_vs");
    tick();

    // Select edge for V in the same cycle as the committing vsync edge.
    edit(2'd0, 3, 1);
    selector = 2'd2;
    inputVal = 3'd5;
    select   = 1'b1;
    model_edit(2'd2, 5);
    act = sh;
    exp_q.push_back(act);
    vsync = 1'b1;
    tick();
    select = 1'b0;
    vsync  = 1'b0;
    @(negedge clk);
    check("sim_h", hThreshold, 8'hF0);
    check("sim_v", vThreshold, 8'hFC);
    check("sim_pend", pending, 0);
    check("sim_upd", upd_pulse, 1);
    wait_not_busy("sim");
    tick();

    // Asynchronous reset at settle cycle 4.
    edit(2'd0, 7, 1);
    do_commit("mid");
    tick();
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    #1;
    check("midrst_busy", cfg_busy, 0);
    check("midrst_pend", pending, 0);
    check("midrst_upd", upd_pulse, 0);
    check_thr("midrst");
    tick();
    tick();
    reset = 1'b1;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    @(negedge clk);
    check("post_rst_upd", upd_pulse, 0);
    check("post_rst_pend", pending, 0);
    tick();
    edit(2'd1, 1, 1);
    @(negedge clk);
    check("post_rst_edit_pend", pending, 1);
    tick();
    do_commit("post_rst");
    check("post_rst_s", sThreshold, 8'hC0);
    wait_not_busy("post_rst");
    tick();

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
